// File: rtl/test_mon_pkg.sv
// Shared types for the riscv-tests pass/fail/timeout/hang monitor.
// Status encodings double as the software-visible result code.
package test_mon_pkg;

  typedef enum logic [2:0] {
    STATUS_IDLE    = 3'd0,
    STATUS_RUN     = 3'd1,
    STATUS_PASS    = 3'd2,
    STATUS_FAIL    = 3'd3,
    STATUS_TIMEOUT = 3'd4,
    STATUS_HANG    = 3'd5
  } status_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_PASS    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_TIMEOUT = 3'd4,
    ST_HANG    = 3'd5
  } state_e;

  localparam int DEF_HANG_CYCLES = 64;

endpackage

// File: rtl/pc_history_buf.sv
// Circular PC history; rd_idx 0 is the most recent write. Synchronous clear
// empties every entry so a re-armed run never shows stale PCs.
module pc_history_buf #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 16,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [XLEN-1:0]  wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [XLEN-1:0]  rd_data
);

  logic [XLEN-1:0]  mem [DEPTH];
  logic [IDX_W-1:0] wr_ptr;
  logic [IDX_W-1:0] rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_ptr] <= wr_data;
      wr_ptr      <= wr_ptr + IDX_W'(1);
    end
  end

  // Pointer arithmetic wraps naturally because DEPTH is a power of two.
  always_comb begin
    rd_ptr  = wr_ptr - IDX_W'(1) - rd_idx;
    rd_data = mem[rd_ptr];
  end

endmodule

// File: rtl/riscv_test_monitor.sv
// Pass/fail/timeout/hang monitor for riscv-tests runs on cpu_top.
// Optional PC history buffer enabled by defining TEST_MON_TRACE_EN.
module riscv_test_monitor
  import test_mon_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int CNT_W       = 24,
  parameter int HANG_CYCLES = DEF_HANG_CYCLES
`ifdef TEST_MON_TRACE_EN
  ,
  parameter int TRACE_DEPTH = 16,
  parameter int TRACE_IDX_W = $clog2(TRACE_DEPTH)
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [XLEN-1:0]  cfg_pass_addr,
  input  logic [XLEN-1:0]  cfg_last_addr,
  input  logic             cfg_last_en,
  input  logic [XLEN-1:0]  cfg_fail_addr,
  input  logic [CNT_W-1:0] cfg_max_cycles,
  input  logic             pc_valid,
  input  logic [XLEN-1:0]  pc_current,
  output logic             done,
  output status_e          status,
  output logic [CNT_W-1:0] cycle_count
`ifdef TEST_MON_TRACE_EN
  ,
  input  logic [TRACE_IDX_W-1:0] trace_rd_idx,
  output logic [XLEN-1:0]        trace_rd_pc
`endif
);

  state_e           state;
  logic [XLEN-1:0]  pass_q, last_q, fail_q, prev_pc;
  logic             last_en_q, prev_vld;
  logic [CNT_W-1:0] max_q, stall, stall_nxt, cnt_inc;
  logic             same_pc, pass_hit, fail_hit, hang_hit, tout_hit;

  // Handshake: pc_valid qualifies pc_current for one cycle; no backpressure.
  always_comb begin
    same_pc   = prev_vld && (pc_current == prev_pc);
    stall_nxt = same_pc ? stall + CNT_W'(1) : '0;
    pass_hit  = pc_valid && (pc_current == pass_q) &&
                (!last_en_q || (prev_vld && (prev_pc == last_q)));
    fail_hit  = pc_valid && (pc_current == fail_q);
    hang_hit  = pc_valid && same_pc && (stall_nxt == CNT_W'(HANG_CYCLES - 1));
    tout_hit  = (max_q != '0) && (cycle_count == max_q - CNT_W'(1));
    cnt_inc   = (&cycle_count) ? cycle_count : cycle_count + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      status      <= STATUS_IDLE;
      done        <= 1'b0;
      cycle_count <= '0;
      prev_pc     <= '0;
      prev_vld    <= 1'b0;
      stall       <= '0;
      pass_q      <= '0;
      last_q      <= '0;
      last_en_q   <= 1'b0;
      fail_q      <= '0;
      max_q       <= '0;
    end else if (start) begin
      state       <= ST_ARMED;
      status      <= STATUS_RUN;
      done        <= 1'b0;
      cycle_count <= '0;
      prev_vld    <= 1'b0;
      stall       <= '0;
      pass_q      <= cfg_pass_addr;
      last_q      <= cfg_last_addr;
      last_en_q   <= cfg_last_en;
      fail_q      <= cfg_fail_addr;
      max_q       <= cfg_max_cycles;
    end else if (state == ST_ARMED) begin
      cycle_count <= cnt_inc;
      if (pc_valid) begin
        prev_pc  <= pc_current;
        prev_vld <= 1'b1;
        stall    <= stall_nxt;
      end
      // Priority: PASS > FAIL > HANG > TIMEOUT.
      if (pass_hit) begin
        state  <= ST_PASS;
        status <= STATUS_PASS;
        done   <= 1'b1;
      end else if (fail_hit) begin
        state  <= ST_FAIL;
        status <= STATUS_FAIL;
        done   <= 1'b1;
      end else if (hang_hit) begin
        state  <= ST_HANG;
        status <= STATUS_HANG;
        done   <= 1'b1;
      end else if (tout_hit) begin
        state  <= ST_TIMEOUT;
        status <= STATUS_TIMEOUT;
        done   <= 1'b1;
      end
    end
  end

`ifdef TEST_MON_TRACE_EN
  pc_history_buf #(
    .XLEN (XLEN),
    .DEPTH(TRACE_DEPTH)
  ) u_hist (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (start),
    .wr_en  ((state == ST_ARMED) && pc_valid && !start),
    .wr_data(pc_current),
    .rd_idx (trace_rd_idx),
    .rd_data(trace_rd_pc)
  );
`endif

endmodule

// File: tb/tb_riscv_test_monitor.sv
// Directed bench for riscv_test_monitor: pass sequencing, fail, timeout,
// hang, priority, re-arm and async reset (plus history when TEST_MON_TRACE_EN).
module tb_riscv_test_monitor;
  import test_mon_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] cfg_pass_addr = '0;
  logic [31:0] cfg_last_addr = '0;
  logic        cfg_last_en = 1'b0;
  logic [31:0] cfg_fail_addr = '0;
  logic [23:0] cfg_max_cycles = '0;
  logic        pc_valid = 1'b0;
  logic [31:0] pc_current = '0;
  logic        done;
  status_e     status;
  logic [23:0] cycle_count;
`ifdef TEST_MON_TRACE_EN
  logic [3:0]  trace_rd_idx = '0;
  logic [31:0] trace_rd_pc;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  riscv_test_monitor dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .cfg_pass_addr (cfg_pass_addr),
    .cfg_last_addr (cfg_last_addr),
    .cfg_last_en   (cfg_last_en),
    .cfg_fail_addr (cfg_fail_addr),
    .cfg_max_cycles(cfg_max_cycles),
    .pc_valid      (pc_valid),
    .pc_current    (pc_current),
    .done          (done),
    .status        (status),
    .cycle_count   (cycle_count)
`ifdef TEST_MON_TRACE_EN
    ,
    .trace_rd_idx  (trace_rd_idx),
    .trace_rd_pc   (trace_rd_pc)
`endif
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Driver tasks: inputs change #1 after posedge, outputs sampled there too.
  task automatic arm(input logic [31:0] pass_a, input logic [31:0] last_a,
                     input logic en, input logic [31:0] fail_a,
                     input logic [23:0] max_c);
    cfg_pass_addr  = pass_a;
    cfg_last_addr  = last_a;
    cfg_last_en    = en;
    cfg_fail_addr  = fail_a;
    cfg_max_cycles = max_c;
    pc_valid       = 1'b0;
    start          = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic step(input logic vld, input logic [31:0] pc);
    pc_valid   = vld;
    pc_current = pc;
    @(posedge clk);
    #1;
    pc_valid   = 1'b0;
  endtask

  task automatic test_reset;
    n_tests++;
    if (status !== STATUS_IDLE || done !== 1'b0 || cycle_count !== 24'd0) begin
      $display("FAIL reset: status=%0d done=%0b count=%0d, want 0/0/0", status, done, cycle_count);
      n_fail++;
    end
    step(1'b1, 32'h394);
    step(1'b1, 32'h4C);
    n_tests++;
    if (status !== STATUS_IDLE || done !== 1'b0 || cycle_count !== 24'd0) begin
      $display("FAIL idle_no_start: status=%0d done=%0b count=%0d, want 0/0/0", status, done, cycle_count);
      n_fail++;
    end
  endtask

  task automatic test_pass_seq;
    arm(32'h394, 32'h374, 1'b1, 32'h4C, 24'd0);
    n_tests++;
    if (status !== STATUS_RUN || cycle_count !== 24'd0 || done !== 1'b0) begin
      $display("FAIL arm: status=%0d count=%0d done=%0b, want 1/0/0", status, cycle_count, done);
      n_fail++;
    end
    step(1'b1, 32'h370);
    step(1'b1, 32'h374);
    n_tests++;
    if (status !== STATUS_RUN) begin
      $display("FAIL pass_early: status=%0d, want %0d", status, STATUS_RUN);
      n_fail++;
    end
    step(1'b1, 32'h394);
    n_tests++;
    if (status !== STATUS_PASS || done !== 1'b1 || cycle_count !== 24'd3) begin
      $display("FAIL pass_seq: status=%0d done=%0b count=%0d, want 2/1/3", status, done, cycle_count);
      n_fail++;
    end
`ifdef TEST_MON_TRACE_EN
    step(1'b1, 32'h500);
    trace_rd_idx = 4'd0;
    #1;
    n_tests++;
    if (trace_rd_pc !== 32'h394) begin
      $display("FAIL trace_idx0: got %h, want 00000394", trace_rd_pc);
      n_fail++;
    end
    trace_rd_idx = 4'd1;
    #1;
    n_tests++;
    if (trace_rd_pc !== 32'h374) begin
      $display("FAIL trace_idx1: got %h, want 00000374", trace_rd_pc);
      n_fail++;
    end
    trace_rd_idx = 4'd3;
    #1;
    n_tests++;
    if (trace_rd_pc !== 32'h0) begin
      $display("FAIL trace_idx3: got %h, want 00000000", trace_rd_pc);
      n_fail++;
    end
    trace_rd_idx = 4'd0;
`endif
  endtask

  task automatic test_pass_order;
    arm(32'h394, 32'h374, 1'b1, 32'h4C, 24'd0);
    step(1'b1, 32'h370);
    step(1'b1, 32'h394);
    n_tests++;
    if (status !== STATUS_RUN || done !== 1'b0) begin
      $display("FAIL pass_wrong_pred: status=%0d done=%0b, want 1/0", status, done);
      n_fail++;
    end
    step(1'b1, 32'h374);
    step(1'b1, 32'h394);
    n_tests++;
    if (status !== STATUS_PASS || cycle_count !== 24'd4) begin
      $display("FAIL pass_late: status=%0d count=%0d, want 2/4", status, cycle_count);
      n_fail++;
    end
    // Without the predecessor requirement, arrival alone suffices.
    arm(32'h394, 32'h374, 1'b0, 32'h4C, 24'd0);
    step(1'b1, 32'h100);
    step(1'b1, 32'h394);
    n_tests++;
    if (status !== STATUS_PASS || cycle_count !== 24'd2) begin
      $display("FAIL pass_no_last: status=%0d count=%0d, want 2/2", status, cycle_count);
      n_fail++;
    end
  endtask

  task automatic test_fail;
    // Budget of 10 also fires on cycle 10: FAIL must win over TIMEOUT.
    arm(32'h394, 32'h374, 1'b1, 32'h4C, 24'd10);
    for (int i = 1; i <= 9; i++) step(1'b1, 32'h100 + 32'(i * 4));
    n_tests++;
    if (status !== STATUS_RUN) begin
      $display("FAIL fail_early: status=%0d, want %0d", status, STATUS_RUN);
      n_fail++;
    end
    step(1'b1, 32'h4C);
    n_tests++;
    if (status !== STATUS_FAIL || done !== 1'b1 || cycle_count !== 24'd10) begin
      $display("FAIL fail_hit: status=%0d done=%0b count=%0d, want 3/1/10", status, done, cycle_count);
      n_fail++;
    end
    step(1'b1, 32'h374);
    step(1'b1, 32'h394);
    n_tests++;
    if (status !== STATUS_FAIL || done !== 1'b1 || cycle_count !== 24'd10) begin
      $display("FAIL fail_sticky: status=%0d done=%0b count=%0d, want 3/1/10", status, done, cycle_count);
      n_fail++;
    end
  endtask

  task automatic test_timeout;
    arm(32'h394, 32'h374, 1'b1, 32'h4C, 24'd100);
    for (int i = 0; i < 99; i++) step(1'b1, 32'h1000 + 32'(i * 4));
    n_tests++;
    if (status !== STATUS_RUN || cycle_count !== 24'd99) begin
      $display("FAIL tout_early: status=%0d count=%0d, want 1/99", status, cycle_count);
      n_fail++;
    end
    step(1'b1, 32'h2000);
    n_tests++;
    if (status !== STATUS_TIMEOUT || done !== 1'b1 || cycle_count !== 24'd100) begin
      $display("FAIL tout_hit: status=%0d done=%0b count=%0d, want 4/1/100", status, done, cycle_count);
      n_fail++;
    end
    arm(32'h394, 32'h374, 1'b1, 32'h4C, 24'd0);
    for (int i = 0; i < 300; i++) step(1'b1, 32'h1000 + 32'(i * 4));
    n_tests++;
    if (status !== STATUS_RUN || done !== 1'b0 || cycle_count !== 24'd300) begin
      $display("FAIL tout_disabled: status=%0d done=%0b count=%0d, want 1/0/300", status, done, cycle_count);
      n_fail++;
    end
  endtask

  task automatic test_hang;
    arm(32'h394, 32'h374, 1'b1, 32'h4C, 24'd0);
    for (int i = 0; i < 10; i++) step(1'b1, 32'h200);
    for (int i = 0; i < 5; i++) step(1'b0, 32'h999);
    for (int i = 0; i < 53; i++) step(1'b1, 32'h200);
    n_tests++;
    if (status !== STATUS_RUN || cycle_count !== 24'd68) begin
      $display("FAIL hang_early: status=%0d count=%0d, want 1/68", status, cycle_count);
      n_fail++;
    end
    step(1'b1, 32'h200);
    n_tests++;
    if (status !== STATUS_HANG || done !== 1'b1 || cycle_count !== 24'd69) begin
      $display("FAIL hang_hit: status=%0d done=%0b count=%0d, want 5/1/69", status, done, cycle_count);
      n_fail++;
    end
  endtask

  task automatic test_rearm_reset;
    arm(32'h300, 32'h374, 1'b0, 32'h300, 24'd0);
    step(1'b1, 32'h300);
    n_tests++;
    if (status !== STATUS_PASS || cycle_count !== 24'd1) begin
      $display("FAIL pass_eq_fail: status=%0d count=%0d, want 2/1", status, cycle_count);
      n_fail++;
    end
    arm(32'h394, 32'h374, 1'b1, 32'h4C, 24'd0);
    n_tests++;
    if (status !== STATUS_RUN || done !== 1'b0 || cycle_count !== 24'd0) begin
      $display("FAIL rearm: status=%0d done=%0b count=%0d, want 1/0/0", status, done, cycle_count);
      n_fail++;
    end
    step(1'b1, 32'h600);
    step(1'b1, 32'h604);
    n_tests++;
    if (cycle_count !== 24'd2) begin
      $display("FAIL rearm_count: count=%0d, want 2", cycle_count);
      n_fail++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (status !== STATUS_IDLE || done !== 1'b0 || cycle_count !== 24'd0) begin
      $display("FAIL async_reset: status=%0d done=%0b count=%0d, want 0/0/0", status, done, cycle_count);
      n_fail++;
    end
    #1;
    rst_n = 1'b1;
    step(1'b1, 32'h394);
    n_tests++;
    if (status !== STATUS_IDLE || cycle_count !== 24'd0) begin
      $display("FAIL post_reset_idle: status=%0d count=%0d, want 0/0", status, cycle_count);
      n_fail++;
    end
  endtask

  initial begin
    #23;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_pass_seq();
    test_pass_order();
    test_fail();
    test_timeout();
    test_hang();
    test_rearm_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
